multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control FSM for the multicycle RV32I core. It sequences the shared ALU, register file, memory port and PC/IR registers through fetch, decode and execute phases. It emits the 2-bit ALUOp that feeds the ALU decoder, plus all datapath mux selects and write enables. It is Moore-style: state decodes to outputs, with one Mealy term for the branch PC write.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- op  in  7  Instr[6:0], valid from DECODE onward
- funct3  in  3  Instr[14:12]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory handshake; present only with MEM_WAIT_EN
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut/Result
- mem_write  out  1  data memory write enable
- ir_write  out  1  IR/OldPC enable
- result_src  out  2  00=ALUOut, 01=ReadData, 10=ALUResult
- alu_src_a  out  2  00=PC, 01=OldPC, 10=RD1
- alu_src_b  out  2  00=WD(RD2), 01=ImmExt, 10=constant 4
- alu_op  out  2  00=add, 01=sub, 10=funct-decoded
- imm_src  out  2  00=I, 01=S, 10=B, 11=J; decoded from op only
- reg_write  out  1  register file write enable
- illegal  out  1  sticky illegal-instruction flag
- instret  out  1  one-cycle pulse on the final cycle of each instruction
- state  out  4  current state encoding, for debug

## Operation
- States and encoding:
  - RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6
  - EXECR=7, EXECI=8, ALUWB=9, JAL=10, BRANCH=11, ILLEGAL=12
- Outputs are 0 except as listed:
  - RESET: all outputs 0.
  - FETCH: ir_write=1, alu_src_b=10, result_src=10, pc_update=1.
  - DECODE: alu_src_a=01, alu_src_b=01. This computes the branch/jal target into ALUOut.
  - MEMADR: alu_src_a=10, alu_src_b=01.
  - MEMREAD: adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, mem_write=1.
  - EXECR: alu_src_a=10, alu_op=10.
  - EXECI: alu_src_a=10, alu_src_b=01, alu_op=10.
  - ALUWB: reg_write=1.
  - JAL: alu_src_a=01, alu_src_b=10, pc_update=1.
  - BRANCH: alu_src_a=10, alu_op=01, branch=1.
  - ILLEGAL: all 0, illegal=1.
- Write-enable logic:
  - pc_write = pc_update | (branch & take).
  - take = zero when funct3=000 (beq); take = ~zero when funct3=001 (bne).
- Transitions:
  - RESET→FETCH, FETCH→DECODE.
  - DECODE by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100011 with funct3 ∈ {000,001} → BRANCH
    - anything else → ILLEGAL
  - MEMADR: op=0000011 → MEMREAD, else MEMWRITE.
  - MEMREAD→MEMWB. EXECR, EXECI, JAL→ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH→FETCH.
  - ILLEGAL→ILLEGAL until reset.
- instret=1 in MEMWB, MEMWRITE, ALUWB and BRANCH.
- imm_src for unlisted opcodes is 00.

## Timing
- Reset:
  - reset_n low forces state=RESET immediately, without waiting for a clock edge; all outputs are 0 and illegal=0.
  - The first FETCH occurs on the first rising edge after reset_n deasserts.
  - Reset mid-instruction abandons it; no write enable is asserted during reset.
- CPI without wait states:
  - lw 5, sw 4, R 4, I 4, jal 4, beq/bne 3.
  - The first instruction completes 1 cycle later than this because of the RESET cycle.
- ALU result timing:
  - ALUOut is valid the cycle after any state that drives the ALU.
  - The branch decision uses zero in the BRANCH cycle itself; this is combinational.
- alu_op changes only on state transitions, so the ALU decoder output is stable for the full cycle.

## Configuration
- Macro: MEM_WAIT_EN.
- With the macro defined:
  - The mem_ready port exists.
  - FETCH, MEMREAD and MEMWRITE hold their state while mem_ready=0.
  - In FETCH, ir_write and pc_update are asserted only in the cycle where mem_ready=1.
  - In MEMWRITE, mem_write stays asserted throughout the wait, and instret fires only on the mem_ready=1 cycle.
  - MEMREAD holds adr_src=1 throughout the wait.
- Without the macro: the mem_ready port is absent, and every state lasts exactly one cycle.

## Test plan
- Reset behaviour: hold reset_n=0 for 3 cycles, then release. Required:
  - state=0 and all outputs 0 during reset.
  - state=1 with ir_write=1 on the first edge after release.
- lw sequence (op=0000011):
  - state sequence 1,2,3,4,5,1.
  - reg_write=1 and result_src=01 only in state 5.
  - instret pulses once.
- beq:
  - op=1100011, funct3=000, zero=1 → pc_write=1 in BRANCH with alu_op=01, back to FETCH after 3 cycles.
  - Same with zero=0 → pc_write=0.
  - bne (funct3=001) with zero=0 → pc_write=1.
- Illegal instruction: op=0110111 in DECODE → state=12 and illegal=1, held for 10+ cycles. Required:
  - no write enables asserted.
  - reset_n low clears illegal to 0.
- Mid-op reset: assert reset_n low asynchronously during MEMWRITE (between clock edges). Required:
  - mem_write drops to 0 immediately, before the next edge.
  - state=0.
- MEM_WAIT_EN: sw with mem_ready=0 for 3 cycles in MEMWRITE. Required:
  - mem_write=1 for 4 cycles.
  - instret pulses only on the mem_ready=1 cycle.
  - ir_write is not asserted in FETCH until mem_ready=1.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle RV32I control FSM driving datapath selects and write enables.
// Optional MEM_WAIT_EN adds mem_ready stalls in FETCH, MEMREAD and MEMWRITE.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
`ifdef MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       illegal,
    output logic       instret,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_ILLEGAL
    } state_t;
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BR = 7'b1100011;
    state_t cur, nxt;
    logic ready, pc_update, branch, take;
`ifdef MEM_WAIT_EN
    assign ready = mem_ready;
`else
    assign ready = 1'b1;
`endif
    assign state   = cur;
    assign illegal = cur == S_ILLEGAL;
    assign take    = funct3 == 3'b000 ? zero : funct3 == 3'b001 ? ~zero : 1'b0;
    assign imm_src = op == OP_SW ? 2'b01 : op == OP_BR ? 2'b10 : op == OP_JAL ? 2'b11 : 2'b00;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cur <= S_RESET;
        else cur <= nxt;
    always_comb begin
        nxt        = cur;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        instret    = 1'b0;
        case (cur)
            S_RESET: nxt = S_FETCH;
            S_FETCH: begin
                nxt        = ready ? S_DECODE : S_FETCH;
                ir_write   = ready;
                pc_update  = ready;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                nxt = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                      op == OP_R   ? S_EXECR :
                      op == OP_I   ? S_EXECI :
                      op == OP_JAL ? S_JAL :
                      (op == OP_BR && funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                nxt       = op == OP_LW ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                nxt     = ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instret    = 1'b1;
                nxt        = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                instret   = ready;
                nxt       = ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                nxt       = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                nxt       = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                instret   = 1'b1;
                nxt       = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                nxt       = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                instret   = 1'b1;
                nxt       = S_FETCH;
            end
            S_ILLEGAL: nxt = S_ILLEGAL;
            default: nxt = S_RESET;
        endcase
        pc_write = pc_update | (branch & take);
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of state sequences and decoded outputs per instruction class.
module tb_multicycle_controller;
    logic       clk = 1'b0, reset_n = 1'b0, zero = 1'b0, mem_ready = 1'b1;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal, instret;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [3:0] state;
    int checks = 0, errors = 0;
    // {pc_write,adr_src,mem_write,ir_write,result_src,alu_src_a,alu_src_b,alu_op,reg_write,illegal,instret}
    wire [14:0] outs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                        alu_op, reg_write, illegal, instret};
    localparam logic [14:0] O_FETCH = 15'b1_0_0_1_10_00_10_00_0_0_0, O_DECODE = 15'b0_0_0_0_00_01_01_00_0_0_0,
                            O_MEMADR = 15'b0_0_0_0_00_10_01_00_0_0_0, O_MEMREAD = 15'b0_1_0_0_00_00_00_00_0_0_0,
                            O_MEMWB = 15'b0_0_0_0_01_00_00_00_1_0_1, O_MEMWR = 15'b0_1_1_0_00_00_00_00_0_0_1,
                            O_EXECR = 15'b0_0_0_0_00_10_00_10_0_0_0, O_EXECI = 15'b0_0_0_0_00_10_01_10_0_0_0,
                            O_ALUWB = 15'b0_0_0_0_00_00_00_00_1_0_1, O_JAL = 15'b1_0_0_0_00_01_10_00_0_0_0,
                            O_BR_T = 15'b1_0_0_0_00_10_00_01_0_0_1, O_BR_N = 15'b0_0_0_0_00_10_00_01_0_0_1,
                            O_ILL = 15'b0_0_0_0_00_00_00_00_0_1_0;

    multicycle_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .zero(zero),
`ifdef MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .imm_src(imm_src), .reg_write(reg_write), .illegal(illegal), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        op = 7'b0000011;
        @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (state !== 4'd0 || outs !== 15'd0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d state=%0d outs=%b expected state=0 outs=0", i, state, outs);
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 4'd1 || ir_write !== 1'b1) begin
            errors++;
            $display("FAIL reset_release state=%0d ir_write=%b expected 1/1", state, ir_write);
        end
    endtask

    task automatic test_lw();
        logic [3:0]  es[6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
        logic [14:0] eo[6] = '{O_FETCH, O_DECODE, O_MEMADR, O_MEMREAD, O_MEMWB, O_FETCH};
        int pulses = 0;
        op = 7'b0000011;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pulses += int'(instret);
            checks++;
            if (state !== es[i] || outs !== eo[i]) begin
                errors++;
                $display("FAIL lw step%0d state=%0d outs=%b expected state=%0d outs=%b", i, state, outs, es[i], eo[i]);
            end
            if (i == 1) begin
                checks++;
                if (imm_src !== 2'b00) begin
                    errors++;
                    $display("FAIL lw_imm imm_src=%b expected 00", imm_src);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL lw_instret pulses=%0d expected 1", pulses);
        end
    endtask

    task automatic test_alu_jal();
        logic [6:0]  ops[3] = '{7'b0110011, 7'b0010011, 7'b1101111};
        logic [3:0]  ex[3]  = '{4'd7, 4'd8, 4'd10};
        logic [14:0] eox[3] = '{O_EXECR, O_EXECI, O_JAL};
        logic [1:0]  eimm[3] = '{2'b00, 2'b00, 2'b11};
        for (int k = 0; k < 3; k++) begin
            op = ops[k];
            do_reset();
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (state !== 4'd2 || imm_src !== eimm[k]) begin
                errors++;
                $display("FAIL alu%0d_decode state=%0d imm=%b expected 2/%b", k, state, imm_src, eimm[k]);
            end
            @(negedge clk);
            checks++;
            if (state !== ex[k] || outs !== eox[k]) begin
                errors++;
                $display("FAIL alu%0d_exec state=%0d outs=%b expected %0d/%b", k, state, outs, ex[k], eox[k]);
            end
            @(negedge clk);
            checks++;
            if (state !== 4'd9 || outs !== O_ALUWB) begin
                errors++;
                $display("FAIL alu%0d_wb state=%0d outs=%b expected 9/%b", k, state, outs, O_ALUWB);
            end
            @(negedge clk);
            checks++;
            if (state !== 4'd1) begin
                errors++;
                $display("FAIL alu%0d_back state=%0d expected 1", k, state);
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0]  f3[4] = '{3'b000, 3'b000, 3'b001, 3'b001};
        logic        zr[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [14:0] eo[4] = '{O_BR_T, O_BR_N, O_BR_T, O_BR_N};
        op = 7'b1100011;
        for (int k = 0; k < 4; k++) begin
            funct3 = f3[k];
            zero = zr[k];
            do_reset();
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (imm_src !== 2'b10) begin
                errors++;
                $display("FAIL br%0d_imm imm_src=%b expected 10", k, imm_src);
            end
            @(negedge clk);
            checks++;
            if (state !== 4'd11 || outs !== eo[k]) begin
                errors++;
                $display("FAIL br%0d state=%0d outs=%b expected 11/%b", k, state, outs, eo[k]);
            end
            @(negedge clk);
            checks++;
            if (state !== 4'd1) begin
                errors++;
                $display("FAIL br%0d_back state=%0d expected 1", k, state);
            end
        end
        funct3 = 3'b010;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (state !== 4'd12) begin
            errors++;
            $display("FAIL br_badf3 state=%0d expected 12", state);
        end
        funct3 = 3'b000;
        zero = 1'b0;
    endtask

    task automatic test_illegal();
        op = 7'b0110111;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checks++;
            if (state !== 4'd12 || outs !== O_ILL) begin
                errors++;
                $display("FAIL illegal cyc%0d state=%0d outs=%b expected 12/%b", i, state, outs, O_ILL);
            end
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (illegal !== 1'b0 || state !== 4'd0) begin
            errors++;
            $display("FAIL illegal_clear illegal=%b state=%0d expected 0/0", illegal, state);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_midop_reset();
        op = 7'b0100011;
        do_reset();
        for (int i = 0; i < 4; i++) @(negedge clk);
        checks++;
        if (state !== 4'd6 || outs !== O_MEMWR || imm_src !== 2'b01) begin
            errors++;
            $display("FAIL sw_memwrite state=%0d outs=%b imm=%b expected 6/%b/01", state, outs, imm_src, O_MEMWR);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || state !== 4'd0 || outs !== 15'd0) begin
            errors++;
            $display("FAIL midop_reset mem_write=%b state=%0d outs=%b expected 0/0/0", mem_write, state, outs);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

`ifdef MEM_WAIT_EN
    task automatic test_mem_wait();
        logic       mr[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] es[9] = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd6, 4'd6, 4'd1};
        logic       eir[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       emw[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       eir2[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        op = 7'b0100011;
        mem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            mem_ready = mr[i];
            #1;
            checks++;
            if (state !== es[i] || ir_write !== eir[i] || mem_write !== emw[i] || instret !== eir2[i]) begin
                errors++;
                $display("FAIL memwait step%0d state=%0d ir=%b mw=%b ins=%b expected %0d/%b/%b/%b",
                         i, state, ir_write, mem_write, instret, es[i], eir[i], emw[i], eir2[i]);
            end
        end
        mem_ready = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_alu_jal();
        test_branch();
        test_illegal();
        test_midop_reset();
`ifdef MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
